// File: rtl/alu_ctrl_sequencer.sv
// Registered ALU control sequencer: accepts an opcode over a valid/ready handshake,
// decodes it through parameter masks into ALU strobes, holds them for EXEC_CYCLES, then pulses done.
module alu_ctrl_sequencer #(
  parameter int                   OP_W        = 4,
  parameter logic [(1<<OP_W)-1:0] LOAD_MASK   = 16'h03FF,
  parameter logic [(1<<OP_W)-1:0] ARITH_MASK  = 16'h038B,
  parameter logic [(1<<OP_W)-1:0] RST_MASK    = 16'h8000,
  parameter int                   EXEC_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [OP_W-1:0] op,
  input  logic            op_valid,
  output logic            op_ready,
  output logic [OP_W-1:0] out_reg,
  output logic            alu_rst,
  output logic            load,
  output logic            arithmetic,
  output logic            busy,
  output logic            done
);

  if (EXEC_CYCLES < 1 || EXEC_CYCLES > 255) begin : g_bad_exec_cycles
    $error("alu_ctrl_sequencer: EXEC_CYCLES must be in 1..255");
  end

  localparam logic [7:0] EXEC_LOAD = 8'(EXEC_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [OP_W-1:0] out_reg_q, out_reg_d;
  logic            alu_rst_q, alu_rst_d;
  logic            load_q, load_d;
  logic            arith_q, arith_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  // Handshake: an opcode transfers on a rising edge where op_valid and op_ready
  // are both high; op_ready is high only in IDLE, so the source must hold op_valid.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    out_reg_d = out_reg_q;
    alu_rst_d = alu_rst_q;
    load_d    = load_q;
    arith_d   = arith_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (op_valid) begin
          state_d   = S_EXEC;
          cnt_d     = EXEC_LOAD;
          out_reg_d = op;
          alu_rst_d = RST_MASK[op];
          load_d    = LOAD_MASK[op];
          arith_d   = ARITH_MASK[op];
          busy_d    = 1'b1;
        end
      end
      S_EXEC: begin
        if (cnt_q == 8'd0) begin
          state_d   = S_DONE;
          alu_rst_d = 1'b0;
          load_d    = 1'b0;
          arith_d   = 1'b0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d   = S_IDLE;
        alu_rst_d = 1'b0;
        load_d    = 1'b0;
        arith_d   = 1'b0;
        busy_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 8'd0;
      out_reg_q <= '0;
      alu_rst_q <= 1'b0;
      load_q    <= 1'b0;
      arith_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      out_reg_q <= out_reg_d;
      alu_rst_q <= alu_rst_d;
      load_q    <= load_d;
      arith_q   <= arith_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign op_ready   = (state_q == S_IDLE);
  assign out_reg    = out_reg_q;
  assign alu_rst    = alu_rst_q;
  assign load       = load_q;
  assign arithmetic = arith_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
